// File: rtl/instr_fetch_decode.sv
// PDP-8 instruction fetch/decode: reads the word at PC, resolves page and
// indirect addressing, and presents one decoded opcode paced by stall.
//
// pdp_mem_opcode packing: [17:12] = {AND,TAD,ISZ,DCA,JMS,JMP}, [11:0] = EA.
// pdp_op7_opcode packing (bit21..bit0): NOP IAC RAL RTL RAR RTR CML CMA CIA
// CLL CLA1 CLA_CLL HLT OSR SKP SNL SZL SZA SNA SMA SPA CLA2.

`ifndef START_ADDRESS
`define START_ADDRESS 12'o0200
`endif

module instr_fetch_decode #(
    parameter logic [11:0] START_ADDRESS = `START_ADDRESS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [11:0] PC_value,
    output logic [11:0] base_addr,
    output logic [17:0] pdp_mem_opcode,
    output logic [21:0] pdp_op7_opcode,
    output logic        mem_rd_req,
    output logic [11:0] mem_rd_addr,
    input  logic [11:0] mem_rd_data,
    input  logic        mem_rd_valid,
    output logic        decode_err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_INST,
        WAIT_IND,
        PRESENT,
        HOLD
    } state_e;

    state_e      state_q;
    logic [17:0] mem_op_q;
    logic [21:0] op7_q;
    logic        req_q;
    logic [11:0] addr_q;
    logic        err_q;
    logic        pend_q;
    logic [4:0]  pc_page_q;
    logic [5:0]  ref_q;

    logic [11:0] w;
    logic [2:0]  op;
    logic        is_mem;
    logic [11:0] ea_d;
    logic [5:0]  ref_d;
    logic [21:0] op7_d;
    logic        err_d;
    logic        rd_ok;

    assign base_addr      = START_ADDRESS;
    assign pdp_mem_opcode = mem_op_q;
    assign pdp_op7_opcode = op7_q;
    assign mem_rd_req     = req_q;
    assign mem_rd_addr    = addr_q;
    assign decode_err     = err_q;

    // Only data answering our own outstanding read is accepted.
    assign rd_ok = mem_rd_valid && pend_q;

    // Decode the returned instruction word into address and opcode bits.
    always_comb begin
        w      = mem_rd_data;
        op     = w[11:9];
        is_mem = (op <= 3'd5);
        ea_d   = w[7] ? {pc_page_q, w[6:0]} : {5'b0, w[6:0]};
        ref_d  = is_mem ? (6'd1 << (3'd5 - op)) : 6'd0;
        op7_d  = '0;
        err_d  = 1'b0;
        if (op == 3'd7) begin
            unique case (w)
                12'o7000: op7_d[21] = 1'b1;
                12'o7001: op7_d[20] = 1'b1;
                12'o7004: op7_d[19] = 1'b1;
                12'o7006: op7_d[18] = 1'b1;
                12'o7010: op7_d[17] = 1'b1;
                12'o7012: op7_d[16] = 1'b1;
                12'o7020: op7_d[15] = 1'b1;
                12'o7040: op7_d[14] = 1'b1;
                12'o7041: op7_d[13] = 1'b1;
                12'o7100: op7_d[12] = 1'b1;
                12'o7200: op7_d[11] = 1'b1;
                12'o7300: op7_d[10] = 1'b1;
                12'o7402: op7_d[9]  = 1'b1;
                12'o7404: op7_d[8]  = 1'b1;
                12'o7410: op7_d[7]  = 1'b1;
                12'o7420: op7_d[6]  = 1'b1;
                12'o7430: op7_d[5]  = 1'b1;
                12'o7440: op7_d[4]  = 1'b1;
                12'o7450: op7_d[3]  = 1'b1;
                12'o7500: op7_d[2]  = 1'b1;
                12'o7510: op7_d[1]  = 1'b1;
                12'o7600: op7_d[0]  = 1'b1;
                default:  err_d     = 1'b1;
            endcase
        end else if (op == 3'd6) begin
            err_d = 1'b1;
        end
        if (err_d) begin
            op7_d[21] = 1'b1;
        end
    end

    // Fetch/decode sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_op_q  <= '0;
            op7_q     <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            pc_page_q <= '0;
            ref_q     <= '0;
        end else begin
            req_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!stall) begin
                        req_q     <= 1'b1;
                        addr_q    <= PC_value;
                        pc_page_q <= PC_value[11:7];
                        pend_q    <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= WAIT_INST;
                end
                WAIT_INST: begin
                    if (rd_ok) begin
                        pend_q <= 1'b0;
                        if (is_mem && w[8]) begin
                            ref_q   <= ref_d;
                            req_q   <= 1'b1;
                            addr_q  <= ea_d;
                            pend_q  <= 1'b1;
                            state_q <= WAIT_IND;
                        end else begin
                            mem_op_q <= is_mem ? {ref_d, ea_d} : 18'd0;
                            op7_q    <= op7_d;
                            err_q    <= err_d;
                            state_q  <= PRESENT;
                        end
                    end
                end
                WAIT_IND: begin
                    if (rd_ok) begin
                        pend_q   <= 1'b0;
                        mem_op_q <= {ref_q, mem_rd_data};
                        state_q  <= PRESENT;
                    end
                end
                PRESENT: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!stall) begin
                        mem_op_q  <= '0;
                        op7_q     <= '0;
                        req_q     <= 1'b1;
                        addr_q    <= PC_value;
                        pc_page_q <= PC_value[11:7];
                        pend_q    <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed instruction vectors, a word-level
// decode model, and a per-cycle compare process on the opcode outputs.

module tb_instr_fetch_decode;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [11:0] PC_value;
    logic [11:0] base_addr;
    logic [17:0] pdp_mem_opcode;
    logic [21:0] pdp_op7_opcode;
    logic        mem_rd_req;
    logic [11:0] mem_rd_addr;
    logic [11:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        decode_err;

    int total = 0;
    int bad   = 0;

    logic        chk_en   = 1'b0;
    logic        chk_mode = 1'b0;
    logic [17:0] exp_mem  = '0;
    logic [21:0] exp_op7  = '0;
    logic        out_tb   = 1'b0;

    // Operate codes indexed by their one-hot bit position.
    localparam logic [11:0] OP7_CODES [22] = '{
        12'o7600, 12'o7510, 12'o7500, 12'o7450, 12'o7440, 12'o7430,
        12'o7420, 12'o7410, 12'o7404, 12'o7402, 12'o7300, 12'o7200,
        12'o7100, 12'o7041, 12'o7040, 12'o7020, 12'o7012, 12'o7010,
        12'o7006, 12'o7004, 12'o7001, 12'o7000
    };

    instr_fetch_decode dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .PC_value       (PC_value),
        .base_addr      (base_addr),
        .pdp_mem_opcode (pdp_mem_opcode),
        .pdp_op7_opcode (pdp_op7_opcode),
        .mem_rd_req     (mem_rd_req),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_rd_valid   (mem_rd_valid),
        .decode_err     (decode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] m_ea(input logic [11:0] w,
                                         input logic [11:0] pc);
        int off  = int'(w) % 128;
        int cur  = (int'(w) / 128) % 2;
        int page = (int'(pc) / 128) * 128;
        return cur != 0 ? 12'(page + off) : 12'(off);
    endfunction

    function automatic bit m_ind(input logic [11:0] w);
        return (int'(w) / 512 < 6) && ((int'(w) / 256) % 2 == 1);
    endfunction

    function automatic logic [17:0] m_mem(input logic [11:0] w,
                                          input logic [11:0] pc,
                                          input logic [11:0] ind);
        int op = int'(w) / 512;
        logic [11:0] ea;
        if (op >= 6) return '0;
        ea = m_ind(w) ? ind : m_ea(w, pc);
        return {6'(1 << (5 - op)), ea};
    endfunction

    function automatic bit m_err(input logic [11:0] w);
        int op = int'(w) / 512;
        if (op == 6) return 1'b1;
        if (op != 7) return 1'b0;
        foreach (OP7_CODES[b]) if (OP7_CODES[b] == w) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [21:0] m_op7(input logic [11:0] w);
        int op = int'(w) / 512;
        if (op < 6) return '0;
        foreach (OP7_CODES[b]) if (OP7_CODES[b] == w) return 22'(1) << b;
        return 22'(1) << 21;
    endfunction

    // Per-cycle compare of the presented opcode and read discipline.
    always @(negedge clk) begin
        if (reset) begin
            out_tb = 1'b0;
        end
        if (chk_en) begin
            chk("base_addr", 32'(base_addr), 32'(12'o0200));
            if (chk_mode) begin
                chk("mem_op", 32'(pdp_mem_opcode), 32'(exp_mem));
                chk("op7_op", 32'(pdp_op7_opcode), 32'(exp_op7));
            end else begin
                chk("mem_zero", 32'(pdp_mem_opcode), 32'd0);
                chk("op7_zero", 32'(pdp_op7_opcode), 32'd0);
            end
            if (mem_rd_req) begin
                chk("one_outstanding", 32'(out_tb), 32'd0);
                out_tb = 1'b1;
            end
            if (mem_rd_valid) out_tb = 1'b0;
        end
    end

    task automatic wait_req(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd_req) begin
                n = i;
                break;
            end
            tick();
        end
    endtask

    task automatic deliver(input int lat, input logic [11:0] d);
        repeat (lat) tick();
        mem_rd_valid = 1'b1;
        mem_rd_data  = d;
        tick();
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
    endtask

    // One instruction: fetch, optional indirect, present, hold under stall.
    task automatic run(input logic [11:0] pc, input logic [11:0] w,
                       input int lat, input logic [11:0] ind,
                       input int ilat, input int hold);
        int n;
        PC_value = pc;
        stall    = 1'b0;
        tick();
        chk_mode = 1'b0;
        wait_req(n);
        chk("fetch_delay", 32'(n), 32'd0);
        chk("fetch_addr", 32'(mem_rd_addr), 32'(pc));
        stall = 1'b1;
        deliver(lat, w);
        if (m_ind(w)) begin
            chk("ind_req", 32'(mem_rd_req), 32'd1);
            chk("ind_addr", 32'(mem_rd_addr), 32'(m_ea(w, pc)));
            deliver(ilat, ind);
        end else begin
            chk("no_ind_req", 32'(mem_rd_req), 32'd0);
        end
        exp_mem  = m_mem(w, pc, ind);
        exp_op7  = m_op7(w);
        chk_mode = 1'b1;
        chk("err_pulse", 32'(decode_err), 32'(m_err(w)));
        tick();
        chk("err_clear", 32'(decode_err), 32'd0);
        repeat (hold - 1) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        stall        = 1'b0;
        PC_value     = 12'o0200;
        mem_rd_data  = '0;
        mem_rd_valid = 1'b0;

        chk("pin_tad", 32'(m_mem(12'o1345, 12'o0220, 12'o0)),
            32'({6'b010000, 12'o0345}));
        chk("pin_jmp_ind", 32'(m_mem(12'o5410, 12'o0220, 12'o3000)),
            32'({6'b000001, 12'o3000}));
        chk("pin_cia", 32'(m_op7(12'o7041)), 32'h0002000);
        chk("pin_spa", 32'(m_op7(12'o7510)), 32'h0000002);
        chk("pin_iot", 32'(m_op7(12'o6032)), 32'h0200000);
        chk("pin_wrap", 32'(m_ea(12'o0200, 12'o7777)), 32'(12'o7600));

        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("reset_req", 32'(mem_rd_req), 32'd0);
        chk("reset_addr", 32'(mem_rd_addr), 32'd0);
        chk("reset_err", 32'(decode_err), 32'd0);
        reset = 1'b0;

        run(12'o0200, 12'o7041, 1, 12'o0, 0, 1);
        run(12'o0220, 12'o1345, 1, 12'o0, 0, 1);
        run(12'o0221, 12'o5410, 2, 12'o3000, 3, 2);
        run(12'o3000, 12'o7510, 1, 12'o0, 0, 1);
        run(12'o3001, 12'o6032, 1, 12'o0, 0, 1);
        run(12'o3002, 12'o7777, 4, 12'o0, 0, 10);
        run(12'o4000, 12'o7300, 1, 12'o0, 0, 1);
        run(12'o7777, 12'o0200, 1, 12'o0, 0, 1);
        run(12'o7777, 12'o4777, 2, 12'o1234, 1, 2);
        run(12'o0400, 12'o3025, 1, 12'o0, 0, 1);
        run(12'o0401, 12'o7402, 1, 12'o0, 0, 1);
        run(12'o0402, 12'o7600, 1, 12'o0, 0, 1);

        PC_value = 12'o0300;
        stall    = 1'b0;
        tick();
        chk_mode = 1'b0;
        chk("mid_fetch", 32'(mem_rd_req), 32'd1);
        stall = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        mem_rd_valid = 1'b1;
        mem_rd_data  = 12'o7402;
        tick();
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        chk("stale_no_req", 32'(mem_rd_req), 32'd0);
        tick();
        chk("stale_no_err", 32'(decode_err), 32'd0);
        run(12'o0301, 12'o2050, 1, 12'o0, 0, 2);
        run(12'o0302, 12'o7001, 1, 12'o0, 0, 1);

        PC_value = 12'o0303;
        stall    = 1'b0;
        tick();
        chk_mode = 1'b0;
        chk("last_fetch", 32'(mem_rd_req), 32'd1);
        reset = 1'b1;
        tick();
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
